// File: rtl/clk_divider_bank_if.sv
// Bundle of per-channel divider controls (enable, divisor, realign pulse) and
// the registered divided-clock / period-start outputs.
interface clk_divider_bank_if #(
  parameter int CH = 4,
  parameter int W  = 32
);
  logic [CH-1:0]   en;
  logic [CH*W-1:0] div;
  logic            sync;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;

  modport master (output en, div, sync, input clk_out, tick);
  modport slave  (input en, div, sync, output clk_out, tick);
endinterface

// File: rtl/clk_divider_bank.sv
// Bank of CH independent integer clock dividers sharing one phase-realign pulse.
// Each channel produces a registered ~50% duty divided clock and a period-start tick.
module clk_divider_bank #(
  parameter int CH = 4,
  parameter int W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  clk_divider_bank_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // High-phase length: ceil(n/2), one bit wider so n = 2^W-1 cannot overflow.
  function automatic logic [W:0] half_period(input logic [W-1:0] n);
    return ({1'b0, n} + {{W{1'b0}}, 1'b1}) >> 1;
  endfunction

  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   nsh_q, nsh_d;
    logic [W-1:0]   div_c;
    logic           clk_q, clk_d;
    logic           tick_q, tick_d;

    assign div_c = bus.div[c*W +: W];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        nsh_q   <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        nsh_q   <= nsh_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nsh_d   = nsh_q;
      clk_d   = 1'b0;
      tick_d  = 1'b0;
      if (!bus.en[c]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        // A zero divisor parks the channel but keeps resampling div every cycle.
        if (state_q == IDLE || bus.sync || nsh_q == '0 || cnt_q == nsh_q - ONE) begin
          nsh_d = div_c;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      if (state_d == RUN && nsh_d != '0) begin
        clk_d  = ({1'b0, cnt_d} < half_period(nsh_d));
        tick_d = (cnt_d == '0);
      end
    end

    assign bus.clk_out[c] = clk_q;
    assign bus.tick[c]    = tick_q;
  end

endmodule

// File: doc/clk_divider_bank.md
CLK_DIVIDER_BANK -- requirements
Module: clk_divider_bank

Interface
REQ-001 Parameter CH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter W, default 32: divisor and counter width per channel (2..32).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  CH  per-channel run enable; bit c controls channel c.
REQ-006 div  input  CH*W  per-channel divisor N, unsigned; channel c occupies bits [c*W +: W].
REQ-007 sync  input  1  single-cycle pulse that realigns the phase of all running channels.
REQ-008 clk_out  output  CH  registered divided clock per channel.
REQ-009 tick  output  CH  registered one-cycle pulse, high in the first cycle of each clk_out period.

Function
REQ-010 Each channel SHALL hold a W-bit counter cnt, a W-bit shadow divisor nsh and a state IDLE or RUN.
REQ-011 IDLE->RUN SHALL occur on the edge where en[c]=1; on that edge nsh<=div[c], cnt<=0, clk_out[c]<=1, tick[c]<=1 (latency 0 cycles from en sampled high).
REQ-012 RUN->IDLE SHALL occur on the edge where en[c]=0; on that edge cnt<=0, clk_out[c]<=0, tick[c]<=0, regardless of phase.
REQ-013 In RUN, cnt SHALL advance by 1 per cycle and wrap to 0 after reaching nsh-1, giving a period of exactly nsh cycles.
REQ-014 clk_out[c] SHALL be 1 while cnt < H and 0 otherwise, where H=(nsh+1)>>1; odd N gives high for (N+1)/2 and low for (N-1)/2 cycles.
REQ-015 tick[c] SHALL be 1 exactly in cycles where cnt==0 in RUN.
REQ-016 div[c] SHALL be resampled into nsh only at the wrap edge (cnt==nsh-1 -> 0) or on IDLE->RUN; mid-period changes of div SHALL NOT alter the current period.
REQ-017 N=1 SHALL give tick[c]=1 every RUN cycle and clk_out[c]=1 constantly.
REQ-018 N=0 SHALL be treated as idle-in-RUN: clk_out[c]=0, tick[c]=0, cnt held at 0; nsh still resampled every cycle so a later nonzero div starts on the next edge with cnt=0, clk_out=1, tick=1.
REQ-019 sync=1 SHALL force, for every channel in RUN, cnt<=0, nsh<=div[c], clk_out<=1, tick<=1 on that edge (N=0 channels excepted per REQ-018).
REQ-020 en[c]=0 SHALL take priority over sync for channel c.
REQ-021 Channels SHALL be fully independent apart from the shared sync.
REQ-022 Counter arithmetic SHALL be W bits, unsigned, with no overflow possible since cnt<nsh<=2^W-1.

Reset
REQ-023 While rst=1, all channels SHALL be in IDLE with cnt=0, nsh=0, clk_out=0 and tick=0, asynchronously to clk.
REQ-024 After rst falls, a channel with en[c]=1 SHALL start per REQ-011 on the first rising edge.
REQ-025 Reset asserted mid-period SHALL drop clk_out and tick to 0 immediately, without waiting for a clock edge.

Verification
REQ-026 N=4, en held high -> clk_out 1,1,0,0 repeating; tick high at cycles 0,4,8.
REQ-027 N=5 -> clk_out 1,1,1,0,0 repeating; tick every 5th cycle starting at cycle 0.
REQ-028 N=6, change div to 2 at cnt=2 -> current period completes as 6 cycles, then 1,0 periods; tick at 0,6,8,10.
REQ-029 Ch0 N=3 and ch1 N=4 running; pulse sync at an arbitrary cycle -> both channels show clk_out=1 and tick=1 on that edge, then restart from cnt=0.
REQ-030 N=1 -> tick constant 1 and clk_out constant 1; N=0 -> both constant 0; switch div 0->3 -> outputs 1,1,0 starting on the next edge.
REQ-031 Assert rst asynchronously mid-high-phase -> clk_out=0 before the next edge; release with en=1 -> tick=1 on the first edge.
